fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue with redirect squash and halt drain.
// Requests are reserved against queue space so a response always has a slot.
// The queue head is presented from output registers, refreshed at every edge.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 10
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic            halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 32 + PC_W;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state_reg;
  logic [PC_W-1:0]  fetch_pc_reg;
  logic             inflight_reg;
  logic [PC_W-1:0]  inflight_pc_reg;
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic [ENT_W-1:0] mem [DEPTH];
  logic             out_valid_reg;
  logic [31:0]      out_instr_reg;
  logic [PC_W-1:0]  out_pc_reg;

  logic             active;
  logic             flush;
  logic             push;
  logic             pop;
  logic             can_issue;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] remain;
  logic [CNT_W-1:0] count_next;
  logic [PTR_W-1:0] head_next;
  logic [PTR_W-1:0] tail_next;
  logic [ENT_W-1:0] push_entry;
  logic [ENT_W-1:0] head_entry_next;

  // Redirect flushes the queue and squashes the response arriving this cycle.
  assign active     = (state_reg != HALTED);
  assign flush      = active && redirect_valid;
  assign push       = active && inflight_reg && !redirect_valid;
  assign pop        = out_valid_reg && out_ready && !flush;
  assign push_entry = {imem_rdata, inflight_pc_reg};

  // Queued entries plus the outstanding request must leave room for one more.
  assign occupancy = count_reg + CNT_W'(inflight_reg);
  assign can_issue = (state_reg == RUN) && (occupancy < DEPTH_CNT)
                     && !redirect_valid && !halt;

  assign imem_req  = can_issue && !reset;
  assign imem_addr = fetch_pc_reg;
  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_pc    = out_pc_reg;
  assign halted    = (state_reg == HALTED);

  // Next queue pointers/count, and the entry that will sit at the head after this edge.
  always_comb begin
    remain     = count_reg - CNT_W'(pop);
    head_next  = head_reg + PTR_W'(pop);
    tail_next  = tail_reg + PTR_W'(push);
    count_next = remain + CNT_W'(push);
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end
    // An empty queue (after the pop) means the new head is the entry being pushed.
    head_entry_next = (remain == '0) ? push_entry : mem[head_next];
  end

  // Queue storage: the response is written at the tail the cycle it arrives.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[tail_reg] <= push_entry;
    end
  end

  // Fetch control FSM, queue bookkeeping and registered head presentation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= RUN;
      fetch_pc_reg    <= '0;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      out_valid_reg   <= 1'b0;
      out_instr_reg   <= '0;
      out_pc_reg      <= '0;
    end else begin
      inflight_reg    <= imem_req;
      inflight_pc_reg <= fetch_pc_reg;
      if (flush) begin
        fetch_pc_reg <= redirect_pc;
      end else if (imem_req) begin
        fetch_pc_reg <= fetch_pc_reg + 1'b1;
      end

      head_reg      <= head_next;
      tail_reg      <= tail_next;
      count_reg     <= count_next;
      out_valid_reg <= (count_next != '0);
      if (count_next != '0) begin
        {out_instr_reg, out_pc_reg} <= head_entry_next;
      end

      case (state_reg)
        RUN: begin
          if (halt) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (redirect_valid || ((count_reg == '0) && !inflight_reg)) begin
            state_reg <= HALTED;
          end
        end
        default: begin
          state_reg <= HALTED;
        end
      endcase
    end
  end

endmodule
